// File: rtl/fft_butterfly_pipe.sv
// Two-stage radix-2 butterfly for an in-place FFT layer: addresses are issued in cycle n,
// RAM/ROM data arrives in cycle n+1, and results plus write strobe are presented in cycle n+2.
module fft_butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TWID_WIDTH = 16,
  parameter int ADDR_SIZE  = 5,
  parameter int SCALE      = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_CS,
  input  logic                    i_rden,
  input  logic                    i_wren,
  input  logic [ADDR_SIZE-1:0]    i_rdaddr_A,
  input  logic [ADDR_SIZE-1:0]    i_rdaddr_B,
  input  logic [2*DATA_WIDTH-1:0] i_rddata_A,
  input  logic [2*DATA_WIDTH-1:0] i_rddata_B,
  input  logic [2*TWID_WIDTH-1:0] i_twiddle,
  input  logic                    i_ovf_clr,
  output logic [ADDR_SIZE-1:0]    o_wraddr_A,
  output logic [ADDR_SIZE-1:0]    o_wraddr_B,
  output logic [2*DATA_WIDTH-1:0] o_wrdata_A,
  output logic [2*DATA_WIDTH-1:0] o_wrdata_B,
  output logic                    o_wren,
  output logic                    o_ovf
);

  localparam int PW = DATA_WIDTH + TWID_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;
  localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (TWID_WIDTH - 2);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  // Handshake: i_rden qualifies the addresses of this cycle; i_wren is sampled one
  // cycle later alongside the returned data; o_wren is a one-cycle write strobe that
  // is forced low whenever i_CS is low, and every register holds while i_CS is low.
  logic [ADDR_SIZE-1:0]    s1_addr_a_q, s1_addr_a_d;
  logic [ADDR_SIZE-1:0]    s1_addr_b_q, s1_addr_b_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [ADDR_SIZE-1:0]    wraddr_a_q, wraddr_a_d;
  logic [ADDR_SIZE-1:0]    wraddr_b_q, wraddr_b_d;
  logic [2*DATA_WIDTH-1:0] wrdata_a_q, wrdata_a_d;
  logic [2*DATA_WIDTH-1:0] wrdata_b_q, wrdata_b_d;
  logic                    r_wren_q, r_wren_d;
  logic                    ovf_q, ovf_d;

  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [TWID_WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0]         p_re_full, p_im_full;
  logic signed [SW-1:0]         p_re, p_im;
  logic signed [SW-1:0]         sum_a_re, sum_a_im, sum_b_re, sum_b_im;
  logic [DATA_WIDTH:0]          ra_re, ra_im, rb_re, rb_im;
  logic                         clip;

  assign a_re = i_rddata_A[2*DATA_WIDTH-1:DATA_WIDTH];
  assign a_im = i_rddata_A[DATA_WIDTH-1:0];
  assign b_re = i_rddata_B[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_im = i_rddata_B[DATA_WIDTH-1:0];
  assign w_re = i_twiddle[2*TWID_WIDTH-1:TWID_WIDTH];
  assign w_im = i_twiddle[TWID_WIDTH-1:0];

  // Optional halving (round half up), then clamp; the MSB of the result flags a clip.
  function automatic logic [DATA_WIDTH:0] finish_sum(input logic signed [SW-1:0] sum);
    logic signed [SW-1:0] v;
    v = sum;
    if (SCALE != 0) v = (v + SW'(1)) >>> 1;
    if (v > MAXV)      return {1'b1, MAXV[DATA_WIDTH-1:0]};
    else if (v < MINV) return {1'b1, MINV[DATA_WIDTH-1:0]};
    else               return {1'b0, v[DATA_WIDTH-1:0]};
  endfunction

  always_comb begin
    p_re_full = (PW'(b_re) * PW'(w_re)) - (PW'(b_im) * PW'(w_im));
    p_im_full = (PW'(b_re) * PW'(w_im)) + (PW'(b_im) * PW'(w_re));
    p_re      = SW'((p_re_full + RND) >>> (TWID_WIDTH - 1));
    p_im      = SW'((p_im_full + RND) >>> (TWID_WIDTH - 1));
    sum_a_re  = SW'(a_re) + p_re;
    sum_a_im  = SW'(a_im) + p_im;
    sum_b_re  = SW'(a_re) - p_re;
    sum_b_im  = SW'(a_im) - p_im;
    ra_re     = finish_sum(sum_a_re);
    ra_im     = finish_sum(sum_a_im);
    rb_re     = finish_sum(sum_b_re);
    rb_im     = finish_sum(sum_b_im);
    clip      = ra_re[DATA_WIDTH] | ra_im[DATA_WIDTH] | rb_re[DATA_WIDTH] | rb_im[DATA_WIDTH];
  end

  always_comb begin
    s1_addr_a_d = s1_addr_a_q;
    s1_addr_b_d = s1_addr_b_q;
    s1_valid_d  = s1_valid_q;
    wraddr_a_d  = wraddr_a_q;
    wraddr_b_d  = wraddr_b_q;
    wrdata_a_d  = wrdata_a_q;
    wrdata_b_d  = wrdata_b_q;
    r_wren_d    = r_wren_q;
    ovf_d       = ovf_q;
    if (i_CS) begin
      s1_addr_a_d = i_rdaddr_A;
      s1_addr_b_d = i_rdaddr_B;
      s1_valid_d  = i_rden;
      wraddr_a_d  = s1_addr_a_q;
      wraddr_b_d  = s1_addr_b_q;
      wrdata_a_d  = {ra_re[DATA_WIDTH-1:0], ra_im[DATA_WIDTH-1:0]};
      wrdata_b_d  = {rb_re[DATA_WIDTH-1:0], rb_im[DATA_WIDTH-1:0]};
      r_wren_d    = s1_valid_q & i_wren;
      // A saturation on a real write takes priority over a clear in the same cycle.
      if (s1_valid_q && i_wren && clip) ovf_d = 1'b1;
      else if (i_ovf_clr)               ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s1_addr_a_q <= '0;
      s1_addr_b_q <= '0;
      s1_valid_q  <= 1'b0;
      wraddr_a_q  <= '0;
      wraddr_b_q  <= '0;
      wrdata_a_q  <= '0;
      wrdata_b_q  <= '0;
      r_wren_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_addr_a_q <= s1_addr_a_d;
      s1_addr_b_q <= s1_addr_b_d;
      s1_valid_q  <= s1_valid_d;
      wraddr_a_q  <= wraddr_a_d;
      wraddr_b_q  <= wraddr_b_d;
      wrdata_a_q  <= wrdata_a_d;
      wrdata_b_q  <= wrdata_b_d;
      r_wren_q    <= r_wren_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_wraddr_A = wraddr_a_q;
  assign o_wraddr_B = wraddr_b_q;
  assign o_wrdata_A = wrdata_a_q;
  assign o_wrdata_B = wrdata_b_q;
  assign o_wren     = r_wren_q & i_CS;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe: a scaled and an unscaled instance share the stimulus;
// a plain-arithmetic butterfly model feeds an expected queue keyed by write cycle.
module tb_fft_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst, cs, rden, wren, ovf_clr;
  logic [4:0]  ra, rb;
  logic [31:0] da, db, tw;
  logic [4:0]  w1a, w1b, w0a, w0b;
  logic [31:0] d1a, d1b, d0a, d0b;
  logic        we1, we0, ov1, ov0;

  always #5 clk = ~clk;

  fft_butterfly_pipe #(.DATA_WIDTH(16), .TWID_WIDTH(16), .ADDR_SIZE(5), .SCALE(1)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_rden(rden), .i_wren(wren),
    .i_rdaddr_A(ra), .i_rdaddr_B(rb), .i_rddata_A(da), .i_rddata_B(db),
    .i_twiddle(tw), .i_ovf_clr(ovf_clr),
    .o_wraddr_A(w1a), .o_wraddr_B(w1b), .o_wrdata_A(d1a), .o_wrdata_B(d1b),
    .o_wren(we1), .o_ovf(ov1));

  fft_butterfly_pipe #(.DATA_WIDTH(16), .TWID_WIDTH(16), .ADDR_SIZE(5), .SCALE(0)) dut0 (
    .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_rden(rden), .i_wren(wren),
    .i_rdaddr_A(ra), .i_rdaddr_B(rb), .i_rddata_A(da), .i_rddata_B(db),
    .i_twiddle(tw), .i_ovf_clr(ovf_clr),
    .o_wraddr_A(w0a), .o_wraddr_B(w0b), .o_wrdata_A(d0a), .o_wrdata_B(d0b),
    .o_wren(we0), .o_ovf(ov0));

  typedef struct {
    int          due;
    logic [4:0]  aa, ab;
    logic [31:0] r1a, r1b, r0a, r0b;
    bit          c1, c0;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_a, pend_b, pend_w;
  bit          pend_wren;
  bit          ovf1_m, ovf0_m;
  int          act, checks, failures, wr_cnt, mark;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_comp(input longint a, input longint p, input bit sub,
                                           input int scale, output bit clip);
    longint s;
    s = sub ? a - p : a + p;
    if (scale != 0) s = (s + 1) >>> 1;
    clip = 1'b0;
    if (s > 32767) begin s = 32767; clip = 1'b1; end
    else if (s < -32768) begin s = -32768; clip = 1'b1; end
    return s[15:0];
  endfunction

  task automatic ref_bfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                          input int scale, output logic [31:0] oa, output logic [31:0] ob,
                          output bit clip);
    longint are, aim, bre, bim, wre, wim, pr, pi;
    bit c0, c1, c2, c3;
    are = longint'($signed(a[31:16])); aim = longint'($signed(a[15:0]));
    bre = longint'($signed(b[31:16])); bim = longint'($signed(b[15:0]));
    wre = longint'($signed(w[31:16])); wim = longint'($signed(w[15:0]));
    pr = (bre * wre - bim * wim + 16384) >>> 15;
    pi = (bre * wim + bim * wre + 16384) >>> 15;
    oa = {ref_comp(are, pr, 1'b0, scale, c0), ref_comp(aim, pi, 1'b0, scale, c1)};
    ob = {ref_comp(are, pr, 1'b1, scale, c2), ref_comp(aim, pi, 1'b1, scale, c3)};
    clip = c0 | c1 | c2 | c3;
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input bit c, input bit rd, input bit wr_plan, input bit clr,
                      input logic [4:0] aa, input logic [4:0] ab,
                      input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xw);
    exp_t e;
    bit   exp_w;
    if (c) begin
      cs = 1'b1; rden = rd; ra = aa; rb = ab; ovf_clr = clr;
      da = pend_a; db = pend_b; tw = pend_w; wren = pend_wren;
      if (rd && wr_plan) begin
        e.due = act + 2; e.aa = aa; e.ab = ab;
        ref_bfly(xa, xb, xw, 1, e.r1a, e.r1b, e.c1);
        ref_bfly(xa, xb, xw, 0, e.r0a, e.r0b, e.c0);
        exp_q.push_back(e);
      end
      pend_wren = wr_plan; pend_a = xa; pend_b = xb; pend_w = xw;
    end else begin
      cs = 1'b0; ovf_clr = 1'b0;
    end
    @(negedge clk);
    exp_w = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == act) begin
      if (exp_q[0].c1) ovf1_m = 1'b1;
      if (exp_q[0].c0) ovf0_m = 1'b1;
      exp_w = c;
    end
    check("wren_s1", we1, exp_w);
    check("wren_s0", we0, exp_w);
    if (exp_w) begin
      e = exp_q.pop_front();
      check("wraddr_a", w1a, e.aa);  check("wraddr_b", w1b, e.ab);
      check("wrdata_a_s1", d1a, e.r1a); check("wrdata_b_s1", d1b, e.r1b);
      check("wrdata_a_s0", d0a, e.r0a); check("wrdata_b_s0", d0b, e.r0b);
    end
    if (we1) wr_cnt++;
    check("ovf_s1", ov1, ovf1_m);
    check("ovf_s0", ov0, ovf0_m);
    @(posedge clk);
    if (c) begin
      act++;
      if (clr) begin ovf1_m = 1'b0; ovf0_m = 1'b0; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rand_step(input bit c);
    step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0,
         5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, {we1, we0}, 2'b00);
    check({tag, "_ovf"}, {ov1, ov0}, 2'b00);
    check({tag, "_addr"}, {w1a, w1b, w0a, w0b}, 20'd0);
    check({tag, "_data_s1"}, {d1a, d1b}, 64'd0);
    check({tag, "_data_s0"}, {d0a, d0b}, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0; wr_cnt = 0; act = 0;
    ovf1_m = 1'b0; ovf0_m = 1'b0; pend_wren = 1'b0;
    pend_a = '0; pend_b = '0; pend_w = '0;
    rst = 1'b1; cs = 1'b0; rden = 1'b0; wren = 1'b0; ovf_clr = 1'b0;
    ra = '0; rb = '0; da = '0; db = '0; tw = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Latency + unity twiddle, then -j twiddle, then saturation.
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd7, {16'd1000, 16'd0}, {16'd500, 16'd0}, {16'h7FFF, 16'h0});
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd9, 32'd0, {16'd0, 16'd100}, {16'h0, 16'h8000});
    check("lat_wren", we1, 1'b1);
    check("lat_addr", {w1a, w1b}, {5'd3, 5'd7});
    check("unity_a", d1a, {16'd750, 16'd0});
    check("unity_b", d1b, {16'd250, 16'd0});
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd4, {16'd32767, 16'd0}, {16'd32767, 16'd0}, {16'h7FFF, 16'h0});
    check("negj_a", d1a, {16'd50, 16'd0});
    check("negj_b", d1b, {16'hFFCE, 16'd0});
    check("negj_ovf", {ov1, ov0}, 2'b00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, {16'd100, 16'd50}, {16'd20, 16'hFFFD}, {16'h7FFF, 16'h0});
    check("sat_a", d0a, {16'd32767, 16'd0});
    check("sat_b", d0b, {16'd1, 16'd0});
    check("sat_ovf", {ov1, ov0}, 2'b01);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 5'd10, {16'd7, 16'd9}, {16'd300, 16'd400}, {16'h4000, 16'h4000});
    idle(3);
    check("ovf_sticky", ov0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check("ovf_clr", ov0, 1'b0);
    idle(1);

    // Stall and drain: 8 butterflies, i_CS low for 3 cycles after the fourth issue.
    mark = wr_cnt;
    for (int i = 0; i < 11; i++) begin
      if (i >= 4 && i < 7) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      else step(1'b1, 1'b1, 1'b1, 1'b0, 5'(i < 4 ? i : i - 3), 5'(i < 4 ? i + 8 : i + 5),
                $urandom, $urandom, $urandom);
    end
    check("stall_pre_drain", wr_cnt - mark, 6);
    idle(4);
    check("stall_total", wr_cnt - mark, 8);

    // Randomized traffic with stalls, discarded entries and clears.
    for (int i = 0; i < 400; i++) rand_step($urandom_range(0, 9) != 0);
    idle(3);

    // Reset with entries in flight.
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 5'd12, $urandom, $urandom, $urandom);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 5'd14, $urandom, $urandom, $urandom);
    check("pre_rst_wren", we1, 1'b1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    ovf1_m = 1'b0; ovf0_m = 1'b0; pend_wren = 1'b0;
    rden = 1'b0; wren = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mark = wr_cnt;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, $urandom, $urandom, $urandom);
    check("post_rst_nowrite", wr_cnt - mark, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 5'd16, $urandom, $urandom, $urandom);
    idle(3);
    check("post_rst_write", wr_cnt - mark, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_pipe.md
# fft_butterfly_pipe

Datapath stage that consumes the read addresses, read enable and write enable produced by an FFT layer address generator. It takes the A/B operands and twiddle returned by synchronous RAMs and computes the radix-2 butterfly A' = A + W·B, B' = A − W·B in fixed point. Results go back to the same addresses (in-place FFT) exactly two clock cycles after the addresses were issued, which matches the layer generator's two-cycle write delay.

## Interface
- DATA_WIDTH, 16, width of each real/imag component of data samples (two's complement)
- TWID_WIDTH, 16, width of each twiddle component, signed Q1.(TWID_WIDTH−1)
- ADDR_SIZE, 5, data memory address width
- SCALE, 1, 1 = divide each butterfly output by 2 (per-layer scaling); 0 = no scaling
- i_CLK  in  1  clock, all state on rising edge
- i_RST  in  1  asynchronous, active-high reset
- i_CS  in  1  stage enable; low = pipeline stall
- i_rden  in  1  read enable from layer generator, qualifies addresses this cycle
- i_wren  in  1  coarse write window from layer generator
- i_rdaddr_A, i_rdaddr_B  in  ADDR_SIZE  addresses issued this cycle
- i_rddata_A, i_rddata_B  in  2·DATA_WIDTH  RAM read data {re,im} (re in upper half), valid one cycle after address
- i_twiddle  in  2·TWID_WIDTH  twiddle ROM data {re,im}, valid one cycle after address
- i_ovf_clr  in  1  synchronous clear of o_ovf
- o_wraddr_A, o_wraddr_B  out  ADDR_SIZE  write-back addresses
- o_wrdata_A, o_wrdata_B  out  2·DATA_WIDTH  butterfly results {re,im}
- o_wren  out  1  write strobe for both result ports
- o_ovf  out  1  sticky saturation flag

## Operation
- Stage 1 (edge ending cycle n): register i_rdaddr_A/B into s1 address registers; s1_valid ← i_rden.
- Stage 2 (edge ending cycle n+1): compute the butterfly from i_rddata_A/B and i_twiddle. Register the results into o_wrdata_A/B. o_wraddr ← s1 addresses; r_wren ← s1_valid & i_wren.
- o_wren = r_wren & i_CS (combinational mask, so no write happens while stalled).
- Complex multiply P = B·W:
  - Pre = Bre·Wre − Bim·Wim, Pim = Bre·Wim + Bim·Wre, computed at full width DATA_WIDTH+TWID_WIDTH+1.
  - Round: add 2^(TWID_WIDTH−2), then arithmetic shift right by TWID_WIDTH−1.
- Sums: A±P computed at DATA_WIDTH+2 bits. If SCALE=1, add 1 then arithmetic shift right 1 (round half up).
- Saturate each component to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. Any clipped component in a cycle where r_wren is set sets o_ovf.
- o_ovf: set by saturation, cleared by i_ovf_clr or reset. Set wins when both occur in the same cycle.
- Twiddle +1.0 is not representable; unity twiddle is 0x7FFF. 0x8000 (−1.0) is legal.
- No state machine. Control is the two-deep valid/address shift pipeline plus the sticky flag.

## Timing
- Reset (async): o_wraddr_A/B = 0, o_wrdata_A/B = 0, o_wren = 0, o_ovf = 0, s1 registers and s1_valid = 0.
- Latency: address with i_rden=1 at cycle n → matching o_wraddr/o_wrdata/o_wren valid during cycle n+2.
- Throughput: one butterfly per cycle, no bubbles while i_CS=1.
- i_CS=0: every pipeline register and o_ovf hold their value; o_wren reads 0. On resume the held entry writes on the first cycle i_CS=1.
- i_rden falling: the two entries already in flight still complete (pipeline drain). This matches the layer's POS_DONE tail.
- i_wren low while s1_valid=1: that entry is discarded (no write), data still computed.
- Reset mid-stream: all in-flight entries are dropped; the first write after release needs a fresh i_rden.
- Consecutive butterflies with overlapping addresses are not hazard-checked. The layer generator guarantees disjoint pairs within a layer.

## Test plan
- Latency: SCALE=1, i_rden=i_wren=1, addresses A=3, B=7 at cycle 0 → cycle 2: o_wraddr_A=3, o_wraddr_B=7, o_wren=1; o_wren=0 at cycles 0–1.
- Unity twiddle: SCALE=1, A=(1000,0), B=(500,0), W=(0x7FFF,0) → o_wrdata_A=(750,0), o_wrdata_B=(250,0), o_ovf=0.
- −j twiddle with negative rounding: SCALE=1, A=(0,0), B=(0,100), W=(0,0x8000) → A'=(50,0), B'=(−50,0).
- Saturation: SCALE=0, A=(32767,0), B=(32767,0), W=(0x7FFF,0):
  - A'=(32767,0) clipped from 65533, B'=(1,0), o_ovf=1.
  - o_ovf stays 1 through later clean butterflies.
  - i_ovf_clr pulse → 0.
- Stall and drain: stream 8 butterflies, drop i_CS for 3 cycles at cycle 4 → o_wren=0 during the stall, no lost or duplicated writes, 8 writes total in address order, 2 writes after i_rden falls.
- Reset mid-stream: assert i_RST with 2 entries in flight → all outputs 0 immediately (asynchronous), no write after release until a new i_rden.
